// File: rtl/rf80386_pkg.sv
// Shared opcode constants and sequencer state encoding for the rel8 branch path.
package rf80386_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEC  = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } seq_state_e;

  localparam logic [7:0] OP_JMPS     = 8'hEB;
  localparam logic [7:0] OP_JCC_BASE = 8'h70;
  localparam logic [7:0] OP_LOOPNZ   = 8'hE0;
  localparam logic [7:0] OP_LOOPZ    = 8'hE1;
  localparam logic [7:0] OP_LOOP     = 8'hE2;
  localparam logic [7:0] OP_JCXZ     = 8'hE3;

  // LOOP family: the only opcodes that decrement the count.
  function automatic logic is_loop(input logic [7:0] ir);
    return (ir == OP_LOOPNZ) || (ir == OP_LOOPZ) || (ir == OP_LOOP);
  endfunction

  // E0-E3: all opcodes that consult the count register.
  function automatic logic is_cx_op(input logic [7:0] ir);
    return ir[7:2] == OP_LOOPNZ[7:2];
  endfunction

endpackage

// File: rtl/evaluate_branch.sv
// Combinational branch-condition evaluator for JMPS, Jcc and the CX-count branches.
module evaluate_branch
  import rf80386_pkg::*;
(
  input  logic [7:0]  ir,
  input  logic        zf,
  input  logic        cf,
  input  logic        sf,
  input  logic        vf,
  input  logic        pf,
  input  logic [31:0] cnt,
  output logic        taken
);

  logic cnt_zero;
  logic cc;

  assign cnt_zero = (cnt == 32'd0);

  always_comb begin
    cc    = 1'b0;
    taken = 1'b0;
    // Jcc condition pairs share ir[3:1]; ir[0] inverts the sense.
    case (ir[3:1])
      3'd0: cc = vf;
      3'd1: cc = cf;
      3'd2: cc = zf;
      3'd3: cc = cf | zf;
      3'd4: cc = sf;
      3'd5: cc = pf;
      3'd6: cc = sf ^ vf;
      3'd7: cc = zf | (sf ^ vf);
      default: cc = 1'b0;
    endcase
    if (ir[7:4] == OP_JCC_BASE[7:4]) begin
      taken = cc ^ ir[0];
    end else begin
      case (ir)
        OP_JMPS:   taken = 1'b1;
        OP_LOOPNZ: taken = !cnt_zero && !zf;
        OP_LOOPZ:  taken = !cnt_zero && zf;
        OP_LOOP:   taken = !cnt_zero;
        OP_JCXZ:   taken = cnt_zero;
        default:   taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// rel8 branch sequencer: IDLE -> [DEC] -> EVAL -> DONE.
// BRANCH_SEQ_LOOP_EN enables the LOOP/JCXZ count path; undefined, E0-E3 complete not taken.
module branch_sequencer
  import rf80386_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        ack_o,
  input  logic [7:0]  ir_i,
  input  logic [7:0]  disp_i,
  input  logic        big_i,
  input  logic [31:0] eip_i,
  input  logic [31:0] ecx_i,
  input  logic        zf_i,
  input  logic        cf_i,
  input  logic        sf_i,
  input  logic        vf_i,
  input  logic        pf_i,
  output logic [31:0] ecx_o,
  output logic        ecx_we_o,
  output logic [31:0] eip_o,
  output logic        done_o,
  output logic        taken_o,
  output logic        flush_o
);

  seq_state_e  state_q, state_d;
  logic [7:0]  ir_q, disp_q;
  logic        big_q;
  logic [31:0] eip_q, cnt_q;
  logic        zf_q, cf_q, sf_q, vf_q, pf_q;
  logic        accept;
  logic        go_dec;
  logic [31:0] cnt_ld;
  logic [31:0] cnt_eval;
  logic [31:0] sdisp, target;
  logic [15:0] target16;
  logic        taken_raw, taken_c;

`ifdef BRANCH_SEQ_LOOP_EN
  // Decrement at acceptance so ecx_o already carries the new count during DEC.
  assign go_dec   = is_loop(ir_i);
  assign cnt_ld   = go_dec ? (big_i ? ecx_i - 32'd1 : {ecx_i[31:16], ecx_i[15:0] - 16'd1})
                           : ecx_i;
  assign ecx_we_o = (state_q == S_DEC);
  assign taken_c  = taken_raw;
`else
  assign go_dec   = 1'b0;
  assign cnt_ld   = ecx_i;
  assign ecx_we_o = 1'b0;
  assign taken_c  = taken_raw & ~is_cx_op(ir_q);
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: if (req_i) begin
        accept  = 1'b1;
        state_d = go_dec ? S_DEC : S_EVAL;
      end
      S_DEC:  state_d = S_EVAL;
      S_EVAL: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A request seen during reset is never latched, so it must not be acked.
  assign ack_o   = accept & ~rst_i;
  assign done_o  = (state_q == S_DONE);
  assign flush_o = done_o & taken_o;

  assign cnt_eval = big_q ? cnt_q : {16'h0, cnt_q[15:0]};
  assign sdisp    = {{24{disp_q[7]}}, disp_q};
  assign target16 = eip_q[15:0] + sdisp[15:0];
  assign target   = big_q ? (eip_q + sdisp) : {16'h0, target16};

  evaluate_branch u_eval (
    .ir    (ir_q),
    .zf    (zf_q),
    .cf    (cf_q),
    .sf    (sf_q),
    .vf    (vf_q),
    .pf    (pf_q),
    .cnt   (cnt_eval),
    .taken (taken_raw)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ir_q    <= 8'h0;
      disp_q  <= 8'h0;
      big_q   <= 1'b0;
      eip_q   <= 32'h0;
      cnt_q   <= 32'h0;
      {zf_q, cf_q, sf_q, vf_q, pf_q} <= 5'h0;
      ecx_o   <= 32'h0;
      eip_o   <= 32'h0;
      taken_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ir_q   <= ir_i;
        disp_q <= disp_i;
        big_q  <= big_i;
        eip_q  <= eip_i;
        cnt_q  <= cnt_ld;
        {zf_q, cf_q, sf_q, vf_q, pf_q} <= {zf_i, cf_i, sf_i, vf_i, pf_i};
        if (go_dec) ecx_o <= cnt_ld;
      end
      if (state_q == S_EVAL) begin
        taken_o <= taken_c;
        eip_o   <= taken_c ? target : eip_q;
      end
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: driver pushes model results, monitor pops on strobes.
module tb_branch_sequencer;

`ifdef BRANCH_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, req_i, ack_o, big_i;
  logic [7:0]  ir_i, disp_i;
  logic [31:0] eip_i, ecx_i, ecx_o, eip_o;
  logic        zf_i, cf_i, sf_i, vf_i, pf_i;
  logic        ecx_we_o, done_o, taken_o, flush_o;

  branch_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .ack_o(ack_o),
    .ir_i(ir_i), .disp_i(disp_i), .big_i(big_i), .eip_i(eip_i), .ecx_i(ecx_i),
    .zf_i(zf_i), .cf_i(cf_i), .sf_i(sf_i), .vf_i(vf_i), .pf_i(pf_i),
    .ecx_o(ecx_o), .ecx_we_o(ecx_we_o), .eip_o(eip_o),
    .done_o(done_o), .taken_o(taken_o), .flush_o(flush_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0]  ir;
    logic [7:0]  disp;
    logic        big;
    logic [31:0] eip;
    logic [31:0] ecx;
    logic [4:0]  fl;   // {zf, cf, sf, vf, pf}
  } req_t;

  typedef struct packed {
    logic [3:0]  lat;
    logic        we;
    logic [31:0] ecx;
    logic [31:0] hold;
    logic        taken;
    logic [31:0] eip;
  } exp_t;

  exp_t        done_q[$];
  logic [31:0] we_q[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, ack_cyc = 0;
  bit          busy = 1'b0;
  logic [31:0] last_ecx = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: architectural meaning of each opcode, computed with plain arithmetic.
  function automatic exp_t model(input req_t r, input logic [31:0] prev_ecx);
    exp_t        e;
    logic [31:0] cnt, tgt;
    logic        zf, cf, sf, vf, pf, c, zero;
    int          d;
    {zf, cf, sf, vf, pf} = r.fl;
    e = '0;
    e.lat = 4'd2;
    c = 1'b0;
    cnt = r.ecx;
    if (r.ir == 8'hEB) c = 1'b1;
    else if (r.ir >= 8'h70 && r.ir <= 8'h7F) begin
      case ((r.ir - 8'h70) / 2)
        0: c = vf;                   // JO
        1: c = cf;                   // JB
        2: c = zf;                   // JE
        3: c = cf || zf;             // JBE
        4: c = sf;                   // JS
        5: c = pf;                   // JP
        6: c = (sf != vf);           // JL
        default: c = zf || (sf != vf); // JLE
      endcase
      if (r.ir % 2 == 1) c = !c;
    end else if (LOOP_EN && r.ir >= 8'hE0 && r.ir <= 8'hE3) begin
      if (r.ir != 8'hE3) begin
        cnt = r.big ? r.ecx - 1 : ((r.ecx & 32'hFFFF_0000) | ((r.ecx - 1) & 32'h0000_FFFF));
        e.we = 1'b1;
        e.ecx = cnt;
        e.lat = 4'd3;
      end
      zero = r.big ? (cnt == 0) : (cnt % 65536 == 0);
      case (r.ir)
        8'hE0: c = !zero && !zf;
        8'hE1: c = !zero && zf;
        8'hE2: c = !zero;
        default: c = zero;
      endcase
    end
    d = $signed(r.disp);
    tgt = r.eip + d;
    if (!r.big) tgt = tgt % 65536;
    e.taken = c;
    e.eip = c ? tgt : r.eip;
    e.hold = e.we ? e.ecx : prev_ecx;
    return e;
  endfunction

  task automatic drive(input req_t r);
    {ir_i, disp_i, big_i, eip_i, ecx_i} = {r.ir, r.disp, r.big, r.eip, r.ecx};
    {zf_i, cf_i, sf_i, vf_i, pf_i} = r.fl;
  endtask

  task automatic scramble();
    {ir_i, disp_i} = 16'($urandom);
    big_i = 1'($urandom);
    eip_i = $urandom;
    ecx_i = $urandom;
    {zf_i, cf_i, sf_i, vf_i, pf_i} = 5'($urandom);
  endtask

  task automatic do_req(input req_t r, input bit hold_req);
    exp_t e;
    int   n;
    e = model(r, last_ecx);
    last_ecx = e.hold;
    done_q.push_back(e);
    if (e.we) we_q.push_back(e.ecx);
    @(posedge clk_i); #1;
    drive(r);
    req_i = 1'b1;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!ack_o && n < 4);
    if (!ack_o) chk("ack_timeout", {31'h0, ack_o}, 32'h1);
    @(posedge clk_i); #1;
    scramble();
    req_i = hold_req ? 1'b1 : 1'($urandom);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!done_o && n < 8);
    if (!done_o) chk("done_timeout", {31'h0, done_o}, 32'h1);
    @(posedge clk_i); #1;
    req_i = 1'b0;
  endtask

  function automatic req_t mk(input logic [7:0] ir, input logic [7:0] disp, input logic big,
                              input logic [31:0] eip, input logic [31:0] ecx, input logic [4:0] fl);
    req_t r;
    r = {ir, disp, big, eip, ecx, fl};
    return r;
  endfunction

  always @(posedge clk_i) cyc++;

  initial forever begin
    @(negedge clk_i);
    if (ack_o) begin
      chk("ack_while_busy", {31'h0, busy}, 32'h0);
      busy = 1'b1;
      ack_cyc = cyc;
    end
    if (ecx_we_o) begin
      if (we_q.size() == 0) chk("ecx_we_expected", 32'(we_q.size()), 32'h1);
      else chk("ecx_o_on_we", ecx_o, we_q.pop_front());
    end
    if (done_o) begin
      if (done_q.size() == 0) chk("done_expected", 32'(done_q.size()), 32'h1);
      else begin
        exp_t e;
        e = done_q.pop_front();
        chk("latency", 32'(cyc - ack_cyc), {28'h0, e.lat});
        chk("taken", {31'h0, taken_o}, {31'h0, e.taken});
        chk("flush", {31'h0, flush_o}, {31'h0, e.taken});
        chk("eip_o", eip_o, e.eip);
        chk("ecx_o_hold", ecx_o, e.hold);
        if (we_q.size() != 0) chk("ecx_we_missing", 32'(we_q.size()), 32'h0);
      end
      busy = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    int   sel;
    rst_i = 1'b1; req_i = 1'b0;
    scramble();
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ack", {31'h0, ack_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_taken", {31'h0, taken_o}, 32'h0);
    chk("rst_flush", {31'h0, flush_o}, 32'h0);
    chk("rst_ecx_we", {31'h0, ecx_we_o}, 32'h0);
    chk("rst_ecx_o", ecx_o, 32'h0);
    chk("rst_eip_o", eip_o, 32'h0);

    // Directed corner cases.
    do_req(mk(8'h74, 8'hF0, 1'b1, 32'h0000_1000, 32'h0, 5'b10000), 1'b1);
    do_req(mk(8'hE2, 8'h10, 1'b1, 32'h0000_2000, 32'h0000_0001, 5'b00000), 1'b1);
    do_req(mk(8'hE2, 8'h20, 1'b0, 32'h0000_FFF0, 32'hABCD_0000, 5'b00000), 1'b0);
    do_req(mk(8'hE3, 8'h08, 1'b0, 32'h0000_3000, 32'h0001_0000, 5'b00000), 1'b1);
    do_req(mk(8'hE3, 8'h08, 1'b1, 32'h0000_3000, 32'h0001_0000, 5'b00000), 1'b0);
    do_req(mk(8'hEB, 8'h80, 1'b1, 32'h0000_0010, 32'h0, 5'b00000), 1'b0);
    do_req(mk(8'h90, 8'h05, 1'b1, 32'h1234_5678, 32'h5, 5'b11111), 1'b1);

    // Reset during the cycle after acceptance (DEC for LOOP, EVAL otherwise).
    r = mk(8'hE2, 8'h04, 1'b1, 32'h0000_4000, 32'h0000_0005, 5'b00000);
    if (LOOP_EN) we_q.push_back(32'h0000_0004);
    @(posedge clk_i); #1;
    drive(r); req_i = 1'b1;
    @(negedge clk_i);
    chk("abort_ack", {31'h0, ack_o}, 32'h1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; req_i = 1'b0; busy = 1'b0; last_ecx = 32'h0;
    @(negedge clk_i);
    chk("abort_done", {31'h0, done_o}, 32'h0);
    chk("abort_taken", {31'h0, taken_o}, 32'h0);
    chk("abort_ecx_o", ecx_o, 32'h0);
    chk("abort_eip_o", eip_o, 32'h0);
    chk("abort_ecx_we", {31'h0, ecx_we_o}, 32'h0);
    repeat (5) @(negedge clk_i);

    // Randomized traffic with bias toward count/displacement boundaries.
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 7);
      r.ir = (sel < 4) ? 8'(8'h70 + $urandom_range(0, 15)) :
             (sel == 4) ? 8'hEB :
             (sel < 7) ? 8'(8'hE0 + $urandom_range(0, 3)) : 8'($urandom);
      r.disp = 8'($urandom);
      r.big = 1'($urandom);
      r.eip = ($urandom_range(0, 3) == 0) ? 32'h0000_FFF8 + $urandom_range(0, 7) : $urandom;
      case ($urandom_range(0, 5))
        0: r.ecx = 32'h0;
        1: r.ecx = 32'h1;
        2: r.ecx = 32'h0001_0000;
        3: r.ecx = 32'h0001_0001;
        4: r.ecx = 32'hFFFF_0001;
        default: r.ecx = $urandom;
      endcase
      r.fl = 5'($urandom);
      do_req(r, 1'($urandom));
    end
    repeat (3) @(negedge clk_i);
    if (done_q.size() != 0) chk("done_q_drained", 32'(done_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
